// File: rtl/stack_cpu_top.sv
// stack_cpu_top: minimal 6502-subset CPU with on-chip ROM ($F000-$FFFF) and RAM ($0000-$01FF).
// Optional macro ILLEGAL_HALT_EN: undefined opcodes halt like BRK instead of running as 1-byte NOPs.

module stack_cpu_mem #(
   parameter int ROM_AW = 12,
   parameter int RAM_AW = 9
) (
   input  logic              clk_i,
   input  logic [15:0]       addr_i,
   input  logic              we_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o,
   input  logic              ld_en_i,
   input  logic [ROM_AW-1:0] ld_addr_i,
   input  logic [7:0]        ld_data_i
);
   logic [7:0] ROM [0:(1<<ROM_AW)-1];
   logic [7:0] RAM [0:(1<<RAM_AW)-1];
   logic       rom_hit;
   logic       ram_hit;

   always_comb begin
      rom_hit = (addr_i[15:ROM_AW] == '1);
      ram_hit = (addr_i[15:RAM_AW] == '0);
      rdata_o = '0;
      if (rom_hit) begin
         rdata_o = ROM[addr_i[ROM_AW-1:0]];
      end else if (ram_hit) begin
         rdata_o = RAM[addr_i[RAM_AW-1:0]];
      end
   end

   // CPU writes only reach RAM; ROM changes solely through the image preload port.
   always_ff @(posedge clk_i) begin
      if (we_i && ram_hit) begin
         RAM[addr_i[RAM_AW-1:0]] <= wdata_i;
      end
      if (ld_en_i) begin
         ROM[ld_addr_i] <= ld_data_i;
      end
   end
endmodule

module stack_cpu_top #(
   parameter int ROM_AW = 12,
   parameter int RAM_AW = 9
) (
   input  logic        ph1,
   input  logic        reset,
   output logic        halted,
   output logic [15:0] dbg_pc
);
   typedef enum logic [2:0] {RST0, RST1, FETCH, CYC2, CYC3, CYC4, HALT} state_t;

   typedef enum logic [7:0] {
      OP_BRK     = 8'h00, OP_PHP     = 8'h08, OP_CLC     = 8'h18, OP_PLP    = 8'h28,
      OP_SEC     = 8'h38, OP_PHA     = 8'h48, OP_JMP     = 8'h4C, OP_PLA    = 8'h68,
      OP_STA_ZP  = 8'h85, OP_STX_ZP  = 8'h86, OP_TXA     = 8'h8A, OP_TXS    = 8'h9A,
      OP_LDX_IMM = 8'hA2, OP_LDA_ZP  = 8'hA5, OP_LDA_IMM = 8'hA9, OP_TAX    = 8'hAA,
      OP_TSX     = 8'hBA, OP_DEX     = 8'hCA, OP_INX     = 8'hE8, OP_NOP    = 8'hEA
   } opcode_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [7:0]  a_q, x_q, s_q, ir_q, tmp_q;
   logic        n_q, v_q, d_q, i_q, z_q, c_q;
   logic        halted_q;

   logic [15:0] addr;
   logic [7:0]  rdata;
   logic [7:0]  wdata;
   logic        we;
   logic        halt_op;
   logic [7:0]  p_byte;
   logic [7:0]  x_inc;
   logic [7:0]  x_dec;

`ifdef ILLEGAL_HALT_EN
   function automatic logic is_legal(input logic [7:0] op);
      case (op)
         OP_BRK, OP_PHP, OP_CLC, OP_PLP, OP_SEC, OP_PHA, OP_JMP, OP_PLA,
         OP_STA_ZP, OP_STX_ZP, OP_TXA, OP_TXS, OP_LDX_IMM, OP_LDA_ZP,
         OP_LDA_IMM, OP_TAX, OP_TSX, OP_DEX, OP_INX, OP_NOP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
`endif

   always_comb begin
      p_byte = {n_q, v_q, 2'b11, d_q, i_q, z_q, c_q};
      x_inc  = x_q + 8'd1;
      x_dec  = x_q - 8'd1;
`ifdef ILLEGAL_HALT_EN
      halt_op = (rdata == OP_BRK) || !is_legal(rdata);
`else
      halt_op = (rdata == OP_BRK);
`endif
   end

   always_comb begin
      addr  = pc_q;
      we    = 1'b0;
      wdata = a_q;
      case (state_q)
         RST0: addr = 16'hFFFC;
         RST1: addr = 16'hFFFD;
         CYC3: begin
            case (ir_q)
               OP_LDA_ZP: addr = {8'h00, tmp_q};
               OP_STA_ZP: begin
                  addr = {8'h00, tmp_q};
                  we   = 1'b1;
               end
               OP_STX_ZP: begin
                  addr  = {8'h00, tmp_q};
                  we    = 1'b1;
                  wdata = x_q;
               end
               OP_PHA: begin
                  addr = {8'h01, s_q};
                  we   = 1'b1;
               end
               OP_PHP: begin
                  addr  = {8'h01, s_q};
                  we    = 1'b1;
                  wdata = p_byte;
               end
               default: ;
            endcase
         end
         CYC4: addr = {8'h01, s_q};
         default: ;
      endcase
   end

   // Write strobe is qualified by reset so an aborted push/store can never land.
   stack_cpu_mem #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) mem (
      .clk_i     (ph1),
      .addr_i    (addr),
      .we_i      (we & reset),
      .wdata_i   (wdata),
      .rdata_o   (rdata),
      .ld_en_i   (1'b0),
      .ld_addr_i ('0),
      .ld_data_i ('0)
   );

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q  <= RST0;
         pc_q     <= '0;
         a_q      <= '0;
         x_q      <= '0;
         s_q      <= 8'hFF;
         ir_q     <= '0;
         tmp_q    <= '0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         d_q      <= 1'b0;
         i_q      <= 1'b1;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            RST0: begin
               pc_q[7:0] <= rdata;
               state_q   <= RST1;
            end
            RST1: begin
               pc_q[15:8] <= rdata;
               state_q    <= FETCH;
            end
            FETCH: begin
               ir_q <= rdata;
               if (halt_op) begin
                  halted_q <= 1'b1;
                  state_q  <= HALT;
               end else begin
                  pc_q    <= pc_q + 16'd1;
                  state_q <= CYC2;
               end
            end
            CYC2: begin
               state_q <= FETCH;
               case (ir_q)
                  OP_LDA_IMM: begin
                     a_q  <= rdata;
                     n_q  <= rdata[7];
                     z_q  <= (rdata == '0);
                     pc_q <= pc_q + 16'd1;
                  end
                  OP_LDX_IMM: begin
                     x_q  <= rdata;
                     n_q  <= rdata[7];
                     z_q  <= (rdata == '0);
                     pc_q <= pc_q + 16'd1;
                  end
                  OP_TAX: begin
                     x_q <= a_q;
                     n_q <= a_q[7];
                     z_q <= (a_q == '0);
                  end
                  OP_TXA: begin
                     a_q <= x_q;
                     n_q <= x_q[7];
                     z_q <= (x_q == '0);
                  end
                  OP_TSX: begin
                     x_q <= s_q;
                     n_q <= s_q[7];
                     z_q <= (s_q == '0);
                  end
                  OP_TXS: s_q <= x_q;
                  OP_INX: begin
                     x_q <= x_inc;
                     n_q <= x_inc[7];
                     z_q <= (x_inc == '0);
                  end
                  OP_DEX: begin
                     x_q <= x_dec;
                     n_q <= x_dec[7];
                     z_q <= (x_dec == '0);
                  end
                  OP_CLC: c_q <= 1'b0;
                  OP_SEC: c_q <= 1'b1;
                  OP_LDA_ZP, OP_STA_ZP, OP_STX_ZP, OP_JMP: begin
                     tmp_q   <= rdata;
                     pc_q    <= pc_q + 16'd1;
                     state_q <= CYC3;
                  end
                  OP_PHA, OP_PHP, OP_PLA, OP_PLP: state_q <= CYC3;
                  default: ;
               endcase
            end
            CYC3: begin
               state_q <= FETCH;
               case (ir_q)
                  OP_LDA_ZP: begin
                     a_q <= rdata;
                     n_q <= rdata[7];
                     z_q <= (rdata == '0);
                  end
                  OP_JMP: pc_q <= {rdata, tmp_q};
                  OP_PHA, OP_PHP: s_q <= s_q - 8'd1;
                  OP_PLA, OP_PLP: begin
                     s_q     <= s_q + 8'd1;
                     state_q <= CYC4;
                  end
                  default: ;
               endcase
            end
            CYC4: begin
               state_q <= FETCH;
               if (ir_q == OP_PLA) begin
                  a_q <= rdata;
                  n_q <= rdata[7];
                  z_q <= (rdata == '0);
               end else begin
                  n_q <= rdata[7];
                  v_q <= rdata[6];
                  d_q <= rdata[3];
                  i_q <= rdata[2];
                  z_q <= rdata[1];
                  c_q <= rdata[0];
               end
            end
            HALT: ;
            default: state_q <= RST0;
         endcase
      end
   end

   always_comb begin
      halted = halted_q;
      dbg_pc = pc_q;
   end
endmodule

// File: tb/tb_stack_cpu_top.sv
// Scoreboard bench for stack_cpu_top: directed and random programs against an instruction-level model.
module tb_stack_cpu_top;
   logic        ph1 = 1'b0;
   logic        reset = 1'b0;
   logic        halted;
   logic [15:0] dbg_pc;

   stack_cpu_top dut (.ph1(ph1), .reset(reset), .halted(halted), .dbg_pc(dbg_pc));

   always #5 ph1 = ~ph1;

`ifdef ILLEGAL_HALT_EN
   localparam bit ILL_HALT = 1'b1;
`else
   localparam bit ILL_HALT = 1'b0;
`endif

   typedef struct {
      int pc; int a; int x; int s; int p; int cyc; int nram;
   } exp_t;

   exp_t       exp_q[$];
   int         ram_addr_q[$];
   int         ram_data_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] prog [0:4095];
   int         ram_m [0:511];
   int         cyc_cnt = 0;
   bit         halt_seen = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit legal(input int op);
      return op inside {'h00, 'h08, 'h18, 'h28, 'h38, 'h48, 'h4C, 'h68, 'h85, 'h86,
                        'h8A, 'h9A, 'hA2, 'hA5, 'hA9, 'hAA, 'hBA, 'hCA, 'hE8, 'hEA};
   endfunction

   function automatic int rd(input int ad);
      if (ad >= 'hF000) return int'(prog[ad - 'hF000]);
      if (ad < 'h200) return ram_m[ad];
      return 0;
   endfunction

   // Instruction-level reference: whole instructions, cycle cost from the opcode table.
   task automatic model_run(input int vec);
      exp_t e;
      bit   wr [0:511];
      int   pc, a, x, s, n, v, d, i, z, c, cyc, op, t;
      pc = vec; a = 0; x = 0; s = 'hFF; n = 0; v = 0; d = 0; i = 1; z = 0; c = 0; cyc = 2;
      foreach (wr[k]) wr[k] = 1'b0;
      for (int steps = 0; steps < 2000; steps++) begin
         op = rd(pc);
         if (op == 0 || (ILL_HALT && !legal(op))) break;
         t = -1;
         case (op)
            'hA9: begin a = rd(pc + 1); t = a; pc += 2; cyc += 2; end
            'hA2: begin x = rd(pc + 1); t = x; pc += 2; cyc += 2; end
            'hAA: begin x = a; t = x; pc += 1; cyc += 2; end
            'h8A: begin a = x; t = a; pc += 1; cyc += 2; end
            'hBA: begin x = s; t = x; pc += 1; cyc += 2; end
            'h9A: begin s = x; pc += 1; cyc += 2; end
            'hE8: begin x = (x + 1) % 256; t = x; pc += 1; cyc += 2; end
            'hCA: begin x = (x + 255) % 256; t = x; pc += 1; cyc += 2; end
            'h18: begin c = 0; pc += 1; cyc += 2; end
            'h38: begin c = 1; pc += 1; cyc += 2; end
            'hA5: begin a = rd(rd(pc + 1)); t = a; pc += 2; cyc += 3; end
            'h85: begin ram_m[rd(pc + 1)] = a; wr[rd(pc + 1)] = 1'b1; pc += 2; cyc += 3; end
            'h86: begin ram_m[rd(pc + 1)] = x; wr[rd(pc + 1)] = 1'b1; pc += 2; cyc += 3; end
            'h4C: begin pc = rd(pc + 1) + 256 * rd(pc + 2); cyc += 3; end
            'h48, 'h08: begin
               ram_m['h100 + s] = (op == 'h48) ? a
                                : (n * 128 + v * 64 + 'h30 + d * 8 + i * 4 + z * 2 + c);
               wr['h100 + s] = 1'b1;
               s = (s + 255) % 256; pc += 1; cyc += 3;
            end
            'h68: begin s = (s + 1) % 256; a = rd('h100 + s); t = a; pc += 1; cyc += 4; end
            'h28: begin
               s = (s + 1) % 256; op = rd('h100 + s);
               n = (op / 128) % 2; v = (op / 64) % 2; d = (op / 8) % 2;
               i = (op / 4) % 2; z = (op / 2) % 2; c = op % 2;
               pc += 1; cyc += 4;
            end
            default: begin pc += 1; cyc += 2; end
         endcase
         if (t >= 0) begin n = t / 128; z = (t == 0); end
      end
      e.pc = pc; e.a = a; e.x = x; e.s = s; e.cyc = cyc; e.nram = 0;
      e.p = n * 128 + v * 64 + 'h30 + d * 8 + i * 4 + z * 2 + c;
      for (int k = 0; k < 512; k++) begin
         if (wr[k]) begin
            ram_addr_q.push_back(k);
            ram_data_q.push_back(ram_m[k]);
            e.nram++;
         end
      end
      exp_q.push_back(e);
   endtask

   always @(posedge ph1) cyc_cnt <= reset ? cyc_cnt + 1 : 0;

   // Monitor: the DUT's observable response is the halt; compare against the oldest expectation.
   initial begin : monitor
      exp_t e;
      int   ad;
      forever begin
         @(negedge ph1);
         if (!reset) begin
            halt_seen = 1'b0;
         end else if (halted && !halt_seen) begin
            halt_seen = 1'b1;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_halt: halted at pc %0h with no pending expectation", dbg_pc);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (cyc_cnt <= e.cyc || cyc_cnt > e.cyc + 2) begin
                  errors++;
                  $display("FAIL halt_cycle: got %0d, expected %0d..%0d", cyc_cnt, e.cyc + 1, e.cyc + 2);
               end
               chk("pc", int'(dbg_pc), e.pc);
               chk("a", int'(dut.a_q), e.a);
               chk("x", int'(dut.x_q), e.x);
               chk("s", int'(dut.s_q), e.s);
               chk("p", int'({dut.n_q, dut.v_q, 2'b11, dut.d_q, dut.i_q, dut.z_q, dut.c_q}), e.p);
               repeat (e.nram) begin
                  ad = ram_addr_q.pop_front();
                  chk($sformatf("ram[%0h]", ad), int'(dut.mem.RAM[ad]), ram_data_q.pop_front());
               end
            end
         end
      end
   end

   task automatic clear_prog();
      for (int k = 0; k < 4096; k++) prog[k] = 8'h00;
   endtask

   task automatic put(inout int p, input int b);
      prog[p] = 8'(b);
      p++;
   endtask

   task automatic start(input int vec);
      #1 reset = 1'b0;
      prog['hFFC] = 8'(vec);
      prog['hFFD] = 8'(vec >> 8);
      for (int k = 0; k < 4096; k++) dut.mem.ROM[k] = prog[k];
   endtask

   task automatic go(input int vec);
      exp_t e;
      model_run(vec);
      @(posedge ph1);
      #1 reset = 1'b1;
      for (int k = 0; k < 3000 && !halt_seen; k++) @(posedge ph1);
      if (!halt_seen) begin
         checks++; errors++;
         $display("FAIL halt_timeout: no halt within 3000 cycles, pc %0h", dbg_pc);
         e = exp_q.pop_back();
         repeat (e.nram) begin
            void'(ram_addr_q.pop_back());
            void'(ram_data_q.pop_back());
         end
      end
   endtask

   task automatic directed(input int b[$]);
      clear_prog();
      foreach (b[k]) prog[k] = 8'(b[k]);
      start('hF000);
      go('hF000);
   endtask

   task automatic check_reset_state();
      chk("rst_halted", int'(halted), 0);
      chk("rst_pc", int'(dbg_pc), 0);
      chk("rst_a", int'(dut.a_q), 0);
      chk("rst_x", int'(dut.x_q), 0);
      chk("rst_s", int'(dut.s_q), 'hFF);
      chk("rst_p", int'({dut.n_q, dut.v_q, 2'b11, dut.d_q, dut.i_q, dut.z_q, dut.c_q}), 'h34);
   endtask

   task automatic gen_random(output int vec);
      int base, p, depth, sel, skip, tgt, nins;
      int zp[$];
      int ill[4] = '{'h02, 'h12, 'hFF, 'h44};
      clear_prog();
      base = $urandom_range(0, 'hD00);
      p = base; depth = 0;
      nins = $urandom_range(8, 24);
      for (int k = 0; k < nins; k++) begin
         sel = $urandom_range(0, 16);
         case (sel)
            0: begin put(p, 'hA9); put(p, $urandom_range(0, 255)); end
            1: begin put(p, 'hA2); put(p, $urandom_range(0, 255)); end
            2: put(p, 'hAA);
            3: put(p, 'h8A);
            4: put(p, 'hBA);
            5: put(p, 'hE8);
            6: put(p, 'hCA);
            7: put(p, 'h18);
            8: put(p, 'h38);
            9: put(p, 'hEA);
            10, 11: begin
               tgt = $urandom_range('h30, 'h3F);
               zp.push_back(tgt);
               put(p, (sel == 10) ? 'h85 : 'h86); put(p, tgt);
            end
            12: if (zp.size() > 0) begin
               put(p, 'hA5); put(p, zp[$urandom_range(0, zp.size() - 1)]);
            end else put(p, 'hEA);
            13: if (depth < 16) begin
               put(p, $urandom_range(0, 1) ? 'h48 : 'h08); depth++;
            end
            14: if (depth > 0) begin
               put(p, $urandom_range(0, 1) ? 'h68 : 'h28); depth--;
            end
            15: begin
               skip = $urandom_range(0, 3);
               tgt = 'hF000 + p + 3 + skip;
               put(p, 'h4C); put(p, tgt); put(p, tgt >> 8);
               repeat (skip) put(p, $urandom_range(0, 255));
            end
            default: put(p, ill[$urandom_range(0, 3)]);
         endcase
      end
      put(p, 'h00);
      vec = 'hF000 + base;
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      int q[$];
      int vec;
      repeat (2) @(posedge ph1);
      #1 check_reset_state();

      q = '{'h00};
      directed(q);
      q = '{'hA9, 'h22, 'h48, 'hA9, 'h00, 'h68, 'h85, 'h30, 'h00};
      directed(q);
      q = '{'hA2, 'h80, 'h9A, 'hA2, 'h00, 'hBA, 'h08, 'h68, 'h85, 'h34, 'h86, 'h31,
            'hA9, 'h00, 'h9A, 'h08, 'h68, 'h85, 'h33, 'h00};
      directed(q);
      q = '{'h38, 'h08, 'h18, 'h28, 'h08, 'h68, 'h85, 'h35, 'h00};
      directed(q);
      q = '{'hA2, 'h00, 'h9A, 'hA9, 'h5A, 'h48, 'hA9, 'h00, 'h68, 'h85, 'h36, 'h00};
      directed(q);
      q = '{'h4C, 'h05, 'hF0, 'h00, 'h00, 'hA9, 'h01, 'h85, 'h38, 'h00};
      directed(q);
      q = '{'hA9, 'h44, 'h02, 'h85, 'h37, 'h00};
      directed(q);

      // Push $11 to $1FF, pull it back, then abort the second push ($77) in its write cycle.
      clear_prog();
      q = '{'hA9, 'h11, 'h48, 'h68, 'hA9, 'h77, 'h48, 'h00};
      foreach (q[k]) prog[k] = 8'(q[k]);
      start('hF000);
      @(posedge ph1);
      #1 reset = 1'b1;
      repeat (15) @(posedge ph1);
      #1 reset = 1'b0;
      #1;
      chk("abort_ram1ff", int'(dut.mem.RAM['h1FF]), 'h11);
      check_reset_state();
      go('hF000);

      for (int r = 0; r < 30; r++) begin
         gen_random(vec);
         start(vec);
         go(vec);
      end

      repeat (3) @(posedge ph1);
      chk("pending_expectations", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stack_cpu_top.md
Name: stack_cpu_top

Overview:
- Minimal 8-bit 6502-compatible CPU plus on-chip memory, used as the system top for regression ROM tests.
- Executes a fixed subset of 6502 opcodes, with the stack and zero-page semantics of the NMOS 6502.
- Benches load the program by hierarchical `$readmemh` into `mem.ROM` and check results by reading `mem.RAM` directly.

Parameters:
- ROM_AW, 12, ROM address width; ROM is 4096 bytes mapped at $F000-$FFFF.
- RAM_AW, 9, RAM address width; RAM is 512 bytes mapped at $0000-$01FF (zero page plus stack page).

Ports:
- ph1  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- halted  output  1  high once the CPU has stopped fetching.
- dbg_pc  output  16  current program counter.

Behaviour:
- Memory instance:
  - Submodule instance named `mem` with arrays `ROM[0:4095]` and `RAM[0:511]`.
  - Reads are combinational; writes happen on the rising edge of ph1.
  - ROM index = addr[11:0] for addr >= $F000. RAM index = addr[8:0] for addr < $0200.
  - Other addresses read $00 and ignore writes.
  - Writes to ROM are ignored. Memory contents are not touched by reset.
- Registers: A, X, S (8-bit), PC (16-bit), flags N, V, D, I, Z, C.
- Reset (reset low, asynchronous):
  - A=X=0, S=$FF, N=V=D=Z=C=0, I=1, halted=0, state=RST0.
  - Outputs: halted=0, dbg_pc=$0000.
- After reset release:
  - RST0 loads PCL from $FFFC; RST1 loads PCH from $FFFD; then FETCH.
  - Reset asserted mid-instruction aborts it at once; a partial write never completes after reset asserts.
- FETCH: opcode = mem[PC], PC+1. Following states fetch operands (PC+1 each), then execute. Cycle counts, including fetch:
  - 2 cycles:
    - LDA #$A9, LDX #$A2
    - TAX $AA, TXA $8A, TSX $BA, TXS $9A
    - INX $E8, DEX $CA
    - CLC $18, SEC $38, NOP $EA
  - 3 cycles:
    - LDA zp $A5, STA zp $85, STX zp $86
    - JMP abs $4C (PC = {hi, lo})
    - PHA $48, PHP $08
  - 4 cycles: PLA $68, PLP $28.
- Push:
  - Write RAM[$0100+S], then S = S-1 (mod 256).
  - PHP pushes {N, V, 1, 1, D, I, Z, C}.
- Pull:
  - S = S+1 (mod 256), then read RAM[$0100+S].
  - PLP loads N, V, D, I, Z, C and ignores bits 5 and 4.
- Stack wrap: S=$00 push writes $0100 and S becomes $FF; S=$FF pull reads $0100.
- Flags:
  - LDA, LDX, TAX, TXA, TSX, PLA, INX, DEX set N=result[7] and Z=(result==0).
  - TXS, STA, STX and pushes leave flags unchanged.
  - INX/DEX wrap mod 256.
- BRK $00: sets halted=1, freezes PC at the BRK address and stops fetching until reset.
- Unknown opcodes: see Optional Feature.
- dbg_pc = PC at all times.

Optional Feature:
- Macro: ILLEGAL_HALT_EN.
- Defined: an undefined opcode behaves as BRK. halted=1 and PC is left pointing at the offending opcode.
- Undefined: an undefined opcode executes as a 2-cycle, 1-byte NOP.

Test Plan:
- Reset vector: ROM[$FFC]=$00, ROM[$FFD]=$F0, ROM[0]=$00 (BRK), release reset -> halted=1 within 4 cycles, dbg_pc=$F000.
- Stack round trip: LDA #$22; PHA; LDA #$00; PLA; STA $30; BRK -> RAM[$30]=$22, S back to $FF, RAM[$1FF]=$22 within 200 cycles.
- TXS/TSX: LDX #$80; TXS; LDX #$00; TSX; STX $31 -> RAM[$31]=$80; TXS leaves Z/N untouched, TSX sets N=1.
- PHP/PLP: SEC; PHP -> pushed byte $35 (I=1, C=1, bits 5 and 4 set); CLC; PLP -> C=1 restored.
- Stack wrap: LDX #$00; TXS; LDA #$5A; PHA -> RAM[$100]=$5A, S=$FF; PLA reads $100 -> A=$5A.
- Async reset mid-PHA: assert reset during the push cycle -> no RAM write, S=$FF, A=0, restart from vector. With ILLEGAL_HALT_EN defined, opcode $02 -> halted=1; without it, execution continues to the next byte.
